// File: rtl/rv32i_bus_pkg.sv
// Shared data-bus types and constants for the RV32I load/store fabric.
// No logic; imported by the demux and its helpers.
package rv32i_bus_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    localparam logic SEL_RAM  = 1'b0;
    localparam logic SEL_MMIO = 1'b1;

    localparam logic [XLEN-1:0] DEFAULT_SPLIT_BASE = 32'h1000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } dbus_state_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Per-transaction cycle counter; expired is decoded from the count register (0-cycle latency).
// No backpressure: counts whenever enabled, clear has priority.
module bus_timeout_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == (limit - 8'd1));

endmodule

// File: rtl/dmem_bus_demux.sv
// Address-split 1-to-2 data bus demux, one transaction in flight; best-case load responds 3 cycles after accept.
// Upstream stalls via req_ready outside IDLE; downstream uses valid/ready, response strobe has no backpressure.
module dmem_bus_demux
    import rv32i_bus_pkg::*;
#(
    parameter logic [XLEN-1:0] SPLIT_BASE = DEFAULT_SPLIT_BASE,
    parameter int              TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            d0_valid,
    input  logic            d0_ready,
    output logic [XLEN-1:0] d0_addr,
    output logic            d0_we,
    output logic [XLEN-1:0] d0_wdata,
    output logic [BE_W-1:0] d0_be,
    input  logic            d0_rsp_valid,
    input  logic [XLEN-1:0] d0_rsp_rdata,
    output logic            d1_valid,
    input  logic            d1_ready,
    output logic [XLEN-1:0] d1_addr,
    output logic            d1_we,
    output logic [XLEN-1:0] d1_wdata,
    output logic [BE_W-1:0] d1_be,
    input  logic            d1_rsp_valid,
    input  logic [XLEN-1:0] d1_rsp_rdata
);

    dbus_state_t     state;
    logic [XLEN-1:0] addr_q;
    logic            we_q;
    logic [XLEN-1:0] wdata_q;
    logic [BE_W-1:0] be_q;
    logic            sel_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            accept;
    logic            busy;
    logic            expired;
    logic            sel_ready;
    logic            sel_rsp_valid;
    logic [XLEN-1:0] sel_rsp_rdata;

    assign accept        = (state == ST_IDLE) && req_valid;
    assign busy          = (state == ST_ISSUE) || (state == ST_WAIT);
    assign sel_ready     = (sel_q == SEL_MMIO) ? d1_ready     : d0_ready;
    assign sel_rsp_valid = (sel_q == SEL_MMIO) ? d1_rsp_valid : d0_rsp_valid;
    assign sel_rsp_rdata = (sel_q == SEL_MMIO) ? d1_rsp_rdata : d0_rsp_rdata;

    bus_timeout_ctr u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (busy),
        .limit   (8'(TIMEOUT)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            sel_q   <= SEL_RAM;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        sel_q   <= (req_addr >= SPLIT_BASE) ? SEL_MMIO : SEL_RAM;
                        if (req_addr[1:0] != 2'b00) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= ST_RESP;
                        end else begin
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= ST_RESP;
                    end else if (sel_ready) begin
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion on the limit cycle beats the timeout.
                    if (sel_rsp_valid) begin
                        rdata_q <= we_q ? '0 : sel_rsp_rdata;
                        err_q   <= 1'b0;
                        state   <= ST_RESP;
                    end else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = (state == ST_RESP) ? rdata_q : '0;
    assign rsp_err   = (state == ST_RESP) ? err_q   : 1'b0;

    // Only the selected port sees the latched fields; the other is held at zero.
    assign d0_valid = (state == ST_ISSUE) && (sel_q == SEL_RAM);
    assign d0_addr  = (sel_q == SEL_RAM) ? addr_q  : '0;
    assign d0_we    = (sel_q == SEL_RAM) ? we_q    : 1'b0;
    assign d0_wdata = (sel_q == SEL_RAM) ? wdata_q : '0;
    assign d0_be    = (sel_q == SEL_RAM) ? be_q    : '0;

    assign d1_valid = (state == ST_ISSUE) && (sel_q == SEL_MMIO);
    assign d1_addr  = (sel_q == SEL_MMIO) ? addr_q  : '0;
    assign d1_we    = (sel_q == SEL_MMIO) ? we_q    : 1'b0;
    assign d1_wdata = (sel_q == SEL_MMIO) ? wdata_q : '0;
    assign d1_be    = (sel_q == SEL_MMIO) ? be_q    : '0;

endmodule

// File: tb/tb_dmem_bus_demux.sv
// Directed bench for dmem_bus_demux: routing, store data masking, misalignment,
// timeout, completion-vs-timeout race and asynchronous reset mid-transaction.
module tb_dmem_bus_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        d0_valid, d1_valid;
    logic        d0_ready, d1_ready;
    logic [31:0] d0_addr, d1_addr;
    logic        d0_we, d1_we;
    logic [31:0] d0_wdata, d1_wdata;
    logic [3:0]  d0_be, d1_be;
    logic        d0_rsp_valid, d1_rsp_valid;
    logic [31:0] d0_rsp_rdata, d1_rsp_rdata;

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;
    int d1_cnt = 0;
    int rsp_base;
    int d1_base;

    dmem_bus_demux dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_wdata    (req_wdata),
        .req_be       (req_be),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .d0_valid     (d0_valid),
        .d0_ready     (d0_ready),
        .d0_addr      (d0_addr),
        .d0_we        (d0_we),
        .d0_wdata     (d0_wdata),
        .d0_be        (d0_be),
        .d0_rsp_valid (d0_rsp_valid),
        .d0_rsp_rdata (d0_rsp_rdata),
        .d1_valid     (d1_valid),
        .d1_ready     (d1_ready),
        .d1_addr      (d1_addr),
        .d1_we        (d1_we),
        .d1_wdata     (d1_wdata),
        .d1_be        (d1_be),
        .d1_rsp_valid (d1_rsp_valid),
        .d1_rsp_rdata (d1_rsp_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (d1_valid)  d1_cnt  <= d1_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic request(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        req_be    = be;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; req_be = '0;
        d0_ready = 1'b0; d1_ready = 1'b0;
        d0_rsp_valid = 1'b0; d1_rsp_valid = 1'b0;
        d0_rsp_rdata = '0; d1_rsp_rdata = '0;

        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err",   rsp_err,   0);
        chk("rst_d0_valid",  d0_valid,  0);
        chk("rst_d1_valid",  d1_valid,  0);
        chk("rst_d0_addr",   d0_addr,   0);
        chk("rst_d1_wdata",  d1_wdata,  0);
        nxt();
        rst_n = 1'b1;
        nxt();
        chk("idle_req_ready", req_ready, 1);

        // Best-case load to RAM
        d1_base = d1_cnt;
        request(32'h0000_0040, 1'b0, 32'h0, 4'hF);
        nxt();
        req_valid = 1'b0;
        chk("ld_req_ready_busy", req_ready, 0);
        chk("ld_d0_valid", d0_valid, 1);
        chk("ld_d0_addr",  d0_addr,  32'h0000_0040);
        chk("ld_d0_we",    d0_we,    0);
        chk("ld_d0_be",    d0_be,    4'hF);
        chk("ld_d1_addr",  d1_addr,  0);
        d0_ready = 1'b1;
        nxt();
        chk("ld_wait_d0_valid", d0_valid, 0);
        d0_ready = 1'b0;
        d0_rsp_valid = 1'b1;
        d0_rsp_rdata = 32'hCAFE_0001;
        nxt();
        d0_rsp_valid = 1'b0;
        chk("ld_rsp_valid", rsp_valid, 1);
        chk("ld_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
        chk("ld_rsp_err",   rsp_err,   0);
        nxt();
        chk("ld_after_rsp_valid", rsp_valid, 0);
        chk("ld_after_req_ready", req_ready, 1);
        chk("ld_d1_never", d1_cnt - d1_base, 0);

        // Store to MMIO at SPLIT_BASE with delayed ready
        request(32'h1000_0000, 1'b1, 32'h1234_5678, 4'b0011);
        nxt();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("st_d1_valid", d1_valid, 1);
            chk("st_d1_addr",  d1_addr,  32'h1000_0000);
            chk("st_d1_we",    d1_we,    1);
            chk("st_d1_wdata", d1_wdata, 32'h1234_5678);
            chk("st_d1_be",    d1_be,    4'b0011);
            chk("st_d0_valid", d0_valid, 0);
            chk("st_d0_wdata", d0_wdata, 0);
            nxt();
        end
        chk("st_d1_valid_last", d1_valid, 1);
        d1_ready = 1'b1;
        nxt();
        d1_ready = 1'b0;
        chk("st_wait_d1_valid", d1_valid, 0);
        d1_rsp_valid = 1'b1;
        d1_rsp_rdata = 32'hDEAD_BEEF;
        nxt();
        d1_rsp_valid = 1'b0;
        chk("st_rsp_valid", rsp_valid, 1);
        chk("st_rsp_rdata", rsp_rdata, 0);
        chk("st_rsp_err",   rsp_err,   0);
        nxt();

        // Misaligned load
        request(32'h0000_0042, 1'b0, 32'h0, 4'hF);
        nxt();
        req_valid = 1'b0;
        chk("mis_rsp_valid", rsp_valid, 1);
        chk("mis_rsp_err",   rsp_err,   1);
        chk("mis_rsp_rdata", rsp_rdata, 0);
        chk("mis_d0_valid",  d0_valid,  0);
        chk("mis_d1_valid",  d1_valid,  0);
        nxt();
        chk("mis_req_ready", req_ready, 1);
        chk("mis_rsp_done",  rsp_valid, 0);

        // Timeout: MMIO accepts but never responds
        request(32'h2000_0000, 1'b0, 32'h0, 4'hF);
        nxt();
        req_valid = 1'b0;
        chk("to_d1_valid", d1_valid, 1);
        d1_ready = 1'b1;
        nxt();
        d1_ready = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            chk("to_no_rsp_early", rsp_valid, 0);
            nxt();
        end
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err",   rsp_err,   1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_d1_valid_off", d1_valid, 0);
        nxt();
        chk("to_req_ready", req_ready, 1);
        chk("to_rsp_done",  rsp_valid, 0);

        // Completion on the timeout-limit cycle
        request(32'h0000_0044, 1'b0, 32'h0, 4'hF);
        nxt();
        req_valid = 1'b0;
        d0_ready = 1'b1;
        nxt();
        d0_ready = 1'b0;
        for (int k = 2; k <= 15; k++) begin
            chk("race_no_rsp_early", rsp_valid, 0);
            nxt();
        end
        d0_rsp_valid = 1'b1;
        d0_rsp_rdata = 32'hA5A5_5A5A;
        chk("race_no_rsp_limit", rsp_valid, 0);
        nxt();
        d0_rsp_valid = 1'b0;
        chk("race_rsp_valid", rsp_valid, 1);
        chk("race_rsp_err",   rsp_err,   0);
        chk("race_rsp_rdata", rsp_rdata, 32'hA5A5_5A5A);
        nxt();

        // Reset during WAIT, then a normal load
        request(32'h0000_0080, 1'b0, 32'h0, 4'hF);
        nxt();
        req_valid = 1'b0;
        chk("rw_d0_valid", d0_valid, 1);
        d0_ready = 1'b1;
        nxt();
        d0_ready = 1'b0;
        chk("rw_req_ready_wait", req_ready, 0);
        rsp_base = rsp_cnt;
        rst_n = 1'b0;
        #1;
        chk("rw_async_req_ready", req_ready, 1);
        chk("rw_async_d0_valid",  d0_valid,  0);
        chk("rw_async_d1_valid",  d1_valid,  0);
        chk("rw_async_rsp_valid", rsp_valid, 0);
        nxt();
        nxt();
        rst_n = 1'b1;
        nxt();
        chk("rw_no_rsp", rsp_cnt - rsp_base, 0);
        chk("rw_idle_ready", req_ready, 1);
        request(32'h0000_0100, 1'b0, 32'h0, 4'hF);
        nxt();
        req_valid = 1'b0;
        chk("rw2_d0_valid", d0_valid, 1);
        chk("rw2_d0_addr",  d0_addr,  32'h0000_0100);
        d0_ready = 1'b1;
        nxt();
        d0_ready = 1'b0;
        d0_rsp_valid = 1'b1;
        d0_rsp_rdata = 32'h0BAD_F00D;
        nxt();
        d0_rsp_valid = 1'b0;
        chk("rw2_rsp_valid", rsp_valid, 1);
        chk("rw2_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        chk("rw2_rsp_err",   rsp_err,   0);
        nxt();
        chk("rw2_rsp_count", rsp_cnt - rsp_base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
